demux_rr_dispatch: RTL and testbench

Registered 1-to-4 stream dispatcher, one pipeline stage upstream of the 4-lane consumers. It takes a single valid/ready input stream and routes each beat to one of four output lanes. The lane is chosen either by an explicit select input or by an internal round-robin pointer. Each lane has a one-entry output register with its own valid/ready handshake, plus a saturating per-lane beat counter for debug.

---
 rtl/demux_rr_dispatch.sv | 124 ++++++++++++
 tb/tb_demux_rr_dispatch.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_rr_dispatch.sv
// Registered 1-to-4 stream dispatcher: routes each input beat to a lane chosen by
// i_sel or a round-robin pointer; each lane is a one-entry register with its own handshake.
module demux_rr_dispatch #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_mode,
  input  logic [1:0]        i_sel,
  input  logic              i_valid,
  input  logic [DW-1:0]     i_data,
  output logic              o_ready,
  output logic [3:0]        o_valid,
  output logic [4*DW-1:0]   o_data,
  input  logic [3:0]        i_lane_ready,
  output logic [4*CW-1:0]   o_beat_cnt,
  output logic [1:0]        o_rr_ptr
);

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_t;

  logic [1:0] w_tgt;
  logic [3:0] w_free;
  logic [3:0] w_load;
  logic       w_accept;
  logic [1:0] r_rr_ptr;
  logic [1:0] w_rr_ptr_next;

  assign w_tgt = i_mode ? r_rr_ptr : i_sel;

  // Ready never looks at i_valid; reset is folded in so nothing is offered while held.
  assign o_ready  = i_rst_n & ~i_flush & w_free[w_tgt];
  assign w_accept = i_valid & o_ready;

  // Pointer stalls on a full target rather than skipping, keeping lane order strictly cyclic.
  always_comb begin
    w_rr_ptr_next = r_rr_ptr;
    if (i_flush) begin
      w_rr_ptr_next = 2'd0;
    end else if (w_accept && i_mode) begin
      w_rr_ptr_next = r_rr_ptr + 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr <= 2'd0;
    end else begin
      r_rr_ptr <= w_rr_ptr_next;
    end
  end

  assign o_rr_ptr = r_rr_ptr;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      lane_state_t   r_state;
      lane_state_t   w_state_next;
      logic [DW-1:0] r_data;
      logic [CW-1:0] r_cnt;

      assign w_free[gi] = (r_state == LANE_EMPTY) | i_lane_ready[gi];
      assign w_load[gi] = w_accept & (w_tgt == 2'(gi));

      always_comb begin
        w_state_next = r_state;
        if (i_flush) begin
          w_state_next = LANE_EMPTY;
        end else begin
          case (r_state)
            LANE_EMPTY: if (w_load[gi]) w_state_next = LANE_FULL;
            LANE_FULL: begin
              // Drain and reload in the same cycle keeps the lane full.
              if (w_load[gi]) begin
                w_state_next = LANE_FULL;
              end else if (i_lane_ready[gi]) begin
                w_state_next = LANE_EMPTY;
              end
            end
            default: w_state_next = LANE_EMPTY;
          endcase
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_state <= LANE_EMPTY;
        end else begin
          r_state <= w_state_next;
        end
      end

      // Data only moves on a load, so it is stable under backpressure.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_data <= '0;
        end else if (w_load[gi]) begin
          r_data <= i_data;
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_cnt <= '0;
        end else if (i_flush) begin
          r_cnt <= '0;
        end else if (w_load[gi] && (r_cnt != {CW{1'b1}})) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign o_valid[gi]             = (r_state == LANE_FULL);
      assign o_data[gi*DW +: DW]     = r_data;
      assign o_beat_cnt[gi*CW +: CW] = r_cnt;
    end
  endgenerate

endmodule

// File: tb/tb_demux_rr_dispatch.sv
// Directed bench for demux_rr_dispatch: a negedge scoreboard tracks per-lane expected
// beats, pointer, counters and ready; the main sequence adds directed spot checks.
module tb_demux_rr_dispatch;
  localparam int DW = 8;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            mode;
  logic [1:0]      sel;
  logic            valid;
  logic [DW-1:0]   data;
  logic            ready;
  logic [3:0]      ovalid;
  logic [4*DW-1:0] odata;
  logic [3:0]      lane_ready;
  logic [4*CW-1:0] cnt;
  logic [1:0]      ptr;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q [4][$];
  logic [1:0]    m_ptr;
  logic [CW-1:0] m_cnt [4];

  always #5 clk = ~clk;

  demux_rr_dispatch #(.DW(DW), .CW(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_mode(mode), .i_sel(sel),
    .i_valid(valid), .i_data(data), .o_ready(ready), .o_valid(ovalid), .o_data(odata),
    .i_lane_ready(lane_ready), .o_beat_cnt(cnt), .o_rr_ptr(ptr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare lane outputs against queued beats, then retire/push for this cycle.
  always @(negedge clk) begin
    logic [1:0] tgt;
    logic       exp_rdy;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        exp_q[k].delete();
        m_cnt[k] = '0;
      end
      m_ptr = 2'd0;
    end else begin
      tgt     = mode ? m_ptr : sel;
      exp_rdy = !flush && ((exp_q[tgt].size() == 0) || lane_ready[tgt]);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("sb_valid%0d", k), {31'd0, ovalid[k]}, {31'd0, exp_q[k].size() != 0});
        if (exp_q[k].size() != 0)
          chk($sformatf("sb_data%0d", k), {24'd0, odata[k*DW +: DW]}, {24'd0, exp_q[k][0]});
        chk($sformatf("sb_cnt%0d", k), {30'd0, cnt[k*CW +: CW]}, {30'd0, m_cnt[k]});
      end
      chk("sb_ptr", {30'd0, ptr}, {30'd0, m_ptr});
      chk("sb_ready", {31'd0, ready}, {31'd0, exp_rdy});
      if (flush) begin
        for (int k = 0; k < 4; k++) begin
          exp_q[k].delete();
          m_cnt[k] = '0;
        end
        m_ptr = 2'd0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (exp_q[k].size() != 0 && lane_ready[k]) begin
            $display("lane %0d out data=%02h", k, exp_q[k][0]);
            void'(exp_q[k].pop_front());
          end
        end
        if (valid && exp_rdy) begin
          $display("in  data=%02h -> lane %0d", data, tgt);
          exp_q[tgt].push_back(data);
          if (m_cnt[tgt] != {CW{1'b1}}) m_cnt[tgt] = m_cnt[tgt] + 1'b1;
          if (mode) m_ptr = m_ptr + 2'd1;
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] stream [5];
    stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rst_n = 1'b0; flush = 1'b0; mode = 1'b0; sel = 2'd0; valid = 1'b0; data = '0;
    lane_ready = 4'h0;
    tick(); tick();
    chk("rst_valid", {28'd0, ovalid}, 32'd0);
    chk("rst_data", odata, 32'd0);
    chk("rst_cnt", {24'd0, cnt}, 32'd0);
    chk("rst_ptr", {30'd0, ptr}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    rst_n = 1'b1;

    // 1: round-robin streaming
    mode = 1'b1; lane_ready = 4'hF; valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data = stream[i];
      #1 chk("t1_ready", {31'd0, ready}, 32'd1);
      tick();
    end
    valid = 1'b0;
    chk("t1_lane0", {24'd0, odata[7:0]}, 32'h55);
    chk("t1_cnt", {24'd0, cnt}, 32'h56);
    chk("t1_ptr", {30'd0, ptr}, 32'd1);
    tick();

    // 2: explicit select with backpressure on lane 2
    mode = 1'b0; sel = 2'd2; lane_ready = 4'b1011; valid = 1'b1; data = 8'hA5;
    tick();
    data = 8'h5A;
    #1 chk("t2_stall_ready", {31'd0, ready}, 32'd0);
    tick(); tick();
    chk("t2_hold", {24'd0, odata[23:16]}, 32'hA5);
    chk("t2_valid", {31'd0, ovalid[2]}, 32'd1);
    lane_ready = 4'hF;
    #1 chk("t2_ready", {31'd0, ready}, 32'd1);
    tick();
    valid = 1'b0;
    chk("t2_land", {24'd0, odata[23:16]}, 32'h5A);
    tick();

    // 3: round-robin stalls on blocked lane 1 without skipping
    lane_ready = 4'h0; valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k); data = 8'(8'hB0 + k);
      tick();
    end
    mode = 1'b1; data = 8'h77; lane_ready = 4'b1101;
    #1 chk("t3_ready", {31'd0, ready}, 32'd0);
    tick(); tick();
    chk("t3_drain", {28'd0, ovalid}, 32'h2);
    chk("t3_ptr_hold", {30'd0, ptr}, 32'd1);
    lane_ready = 4'hF;
    #1 chk("t3_unblock", {31'd0, ready}, 32'd1);
    tick();
    valid = 1'b0;
    chk("t3_lane1", {24'd0, odata[15:8]}, 32'h77);
    chk("t3_ptr", {30'd0, ptr}, 32'd2);
    tick();

    // 4: lane-3 counter saturates
    mode = 1'b0; sel = 2'd3; valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data = 8'(8'hC0 + i);
      tick();
    end
    valid = 1'b0;
    chk("t4_sat", {30'd0, cnt[7:6]}, 32'd3);
    tick();

    // 5: flush with lanes 0 and 2 stalled, pointer at 3
    lane_ready = 4'h0; valid = 1'b1; mode = 1'b0; sel = 2'd0; data = 8'hD0;
    tick();
    mode = 1'b1; data = 8'hD2;
    tick();
    chk("t5_ptr3", {30'd0, ptr}, 32'd3);
    mode = 1'b1; data = 8'hD3; flush = 1'b1; lane_ready = 4'h0;
    #1 chk("t5_flush_ready", {31'd0, ready}, 32'd0);
    tick();
    flush = 1'b0;
    chk("t5_valid", {28'd0, ovalid}, 32'd0);
    chk("t5_ptr", {30'd0, ptr}, 32'd0);
    chk("t5_cnt", {24'd0, cnt}, 32'd0);
    #1 chk("t5_ready", {31'd0, ready}, 32'd1);
    tick();
    chk("t5_lane0", {24'd0, odata[7:0]}, 32'hD3);
    chk("t5_v0", {28'd0, ovalid}, 32'd1);

    // 6: async reset mid-stream
    data = 8'hE1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", {28'd0, ovalid}, 32'd0);
    chk("t6_data", odata, 32'd0);
    chk("t6_cnt", {24'd0, cnt}, 32'd0);
    chk("t6_ready", {31'd0, ready}, 32'd0);
    tick();
    rst_n = 1'b1; lane_ready = 4'hF; data = 8'hC3;
    tick();
    valid = 1'b0;
    chk("t6_resume", {24'd0, odata[7:0]}, 32'hC3);
    chk("t6_ptr", {30'd0, ptr}, 32'd1);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
